// File: rtl/bit_tick_gen.sv
// Free-running bit-period divider: while run is high, tick pulses in the last
// of every DIV cycles. Holding run low or pulsing clear restarts the period.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = run && (div_cnt == LAST);

  // The count restarts on every tick, so it never passes DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clear || !run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sll_serializer.sv
// Parallel-in, serial-out transmitter: sends a BITS-wide word MSB first, DIV
// cycles per bit, with a per-bit strobe for sll_register and a done pulse.
module sll_serializer #(
  parameter int BITS = 32,
  parameter int DIV  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_sclr,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_data,
  output logic            o_ready,
  output logic            o_dat,
  output logic            o_en,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BW = $clog2(BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] shift_reg;
  logic [BW-1:0]   bit_cnt;
  logic            done_q;
  logic            running;
  logic            tick;
  logic            load;
  logic            last;

  assign running = (state == SHIFT);
  assign o_done  = done_q;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(i_sclr),
    .run  (running),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear overrides both the load decision and the final-bit exit.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_en      = 1'b0;
    o_dat     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_busy = 1'b1;
        o_en   = tick;
        o_dat  = shift_reg[BITS-1];
        if (tick && (bit_cnt == LAST_BIT)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_sclr) begin
      state_nxt = IDLE;
      load      = 1'b0;
      last      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last;
      if (i_sclr) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (load) begin
        shift_reg <= i_data;
        bit_cnt   <= '0;
      end else if (running && tick) begin
        shift_reg <= {shift_reg[BITS-2:0], 1'b0};
        bit_cnt   <= last ? '0 : bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sll_serializer.sv
// Self-checking bench for sll_serializer: an 8-bit/DIV=1 and a 4-bit/DIV=3 instance
// checked against directed vectors and a cycle-arithmetic reference model.
module tb_sll_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sclr8, valid8;
  logic [7:0] data8;
  logic       ready8, dat8, en8, busy8, done8;
  logic       sclr4, valid4;
  logic [3:0] data4;
  logic       ready4, dat4, en4, busy4, done4;

  sll_serializer #(.BITS(8), .DIV(1)) dut8 (
    .clk(clk), .rst(rst), .i_sclr(sclr8), .i_valid(valid8), .i_data(data8),
    .o_ready(ready8), .o_dat(dat8), .o_en(en8), .o_busy(busy8), .o_done(done8)
  );

  sll_serializer #(.BITS(4), .DIV(3)) dut4 (
    .clk(clk), .rst(rst), .i_sclr(sclr4), .i_valid(valid4), .i_data(data4),
    .o_ready(ready4), .o_dat(dat4), .o_en(en4), .o_busy(busy4), .o_done(done4)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc8  = -1;
  int acc4  = -1;
  logic [31:0] w8 = '0;
  logic [31:0] w4 = '0;

  // Loopback receiver standing in for sll_register: shifts o_dat in on each o_en edge.
  logic [7:0] rx;
  int         rx_cnt;
  logic       rx_clr = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rx     <= '0;
      rx_cnt <= 0;
    end else if (rx_clr) begin
      rx     <= '0;
      rx_cnt <= 0;
    end else if (en8) begin
      rx     <= {rx[6:0], dat8};
      rx_cnt <= rx_cnt + 1;
    end
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[11];

  // Word accepted at the edge closing cycle acc: bits fill cycles acc+1..acc+b*d,
  // done in cycle acc+b*d+1. Result is {ready, dat, en, busy, done}.
  function automatic logic [4:0] expectOut(input int b, input int d, input int acc,
                                           input logic [31:0] w, input int c);
    int j;
    if (acc >= 0 && c > acc && c <= acc + b * d) begin
      j = c - acc - 1;
      return {1'b0, w[b - 1 - j / d], (j % d) == d - 1, 1'b1, 1'b0};
    end
    return {1'b1, 1'b0, 1'b0, 1'b0, (acc >= 0) && (c == acc + b * d + 1)};
  endfunction

  function automatic logic modelIdle(input int b, input int d, input int acc, input int c);
    return !(acc >= 0 && c > acc && c <= acc + b * d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [4:0] e8, e4;
    e8 = expectOut(8, 1, acc8, w8, cyc);
    e4 = expectOut(4, 3, acc4, w4, cyc);
    checkOutput({tag, "_b8"}, {27'b0, ready8, dat8, en8, busy8, done8}, {27'b0, e8});
    checkOutput({tag, "_b4"}, {27'b0, ready4, dat4, en4, busy4, done4}, {27'b0, e4});
    if (e8[0]) checkOutput({tag, "_loop"}, {24'b0, rx}, w8);
  endtask

  // Drives one cycle of inputs, advances the model over the closing edge, and
  // returns at the following negedge where outputs are sampled.
  task automatic applyStimulus(input logic s8, input logic v8, input logic [7:0] d8,
                               input logic s4, input logic v4, input logic [3:0] d4);
    sclr8 = s8; valid8 = v8; data8 = d8;
    sclr4 = s4; valid4 = v4; data4 = d4;
    if (s8) acc8 = -1;
    else if (v8 && modelIdle(8, 1, acc8, cyc)) begin acc8 = cyc; w8 = {24'b0, d8}; end
    if (s4) acc4 = -1;
    else if (v4 && modelIdle(4, 3, acc4, cyc)) begin acc4 = cyc; w4 = {28'b0, d4}; end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    sclr8 = 0; valid8 = 0; data8 = '0;
    sclr4 = 0; valid4 = 0; data4 = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_b8", {27'b0, ready8, dat8, en8, busy8, done8}, 32'b10000);
    checkOutput("reset_b4", {27'b0, ready4, dat4, en4, busy4, done4}, 32'b10000);
    rst = 1'b0;
    @(negedge clk);

    // A5, DIV=1: one bit per cycle, done right after the eighth bit.
    tbl[0]  = '{1'b1, 8'hA5, 5'b10000};
    tbl[1]  = '{1'b0, 8'h00, 5'b01110};
    tbl[2]  = '{1'b0, 8'h00, 5'b00110};
    tbl[3]  = '{1'b0, 8'h00, 5'b01110};
    tbl[4]  = '{1'b0, 8'h00, 5'b00110};
    tbl[5]  = '{1'b0, 8'h00, 5'b00110};
    tbl[6]  = '{1'b0, 8'h00, 5'b01110};
    tbl[7]  = '{1'b0, 8'h00, 5'b00110};
    tbl[8]  = '{1'b0, 8'h00, 5'b01110};
    tbl[9]  = '{1'b0, 8'h00, 5'b10001};
    tbl[10] = '{1'b0, 8'h00, 5'b10000};
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("t1_vec%0d", i), {27'b0, ready8, dat8, en8, busy8, done8},
                  {27'b0, tbl[i].exp});
      applyStimulus(1'b0, tbl[i].valid, tbl[i].data, 1'b0, 1'b0, 4'h0);
    end

    // Loopback of 3C into the receiver model.
    rx_clr = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 4'h0);
    rx_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkModel("t2");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end
    checkOutput("t2_done", {31'b0, done8}, 32'd1);
    checkOutput("t2_rx", {24'b0, rx}, 32'h3C);
    checkOutput("t2_en_count", 32'(rx_cnt), 32'd8);

    // 1001 with DIV=3: strobes on the third cycle of each bit, done at k+13.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b1001);
    for (int n = 1; n <= 13; n++) begin
      checkOutput($sformatf("t3_n%0d", n), {27'b0, ready4, dat4, en4, busy4, done4},
                  {27'b0, n == 13, (n <= 3) || (n >= 10 && n <= 12),
                   n == 3 || n == 6 || n == 9 || n == 12, n <= 12, n == 13});
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end

    // FF held valid during a 00 transfer is taken only in the done cycle.
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      checkModel("t4_busy");
      checkOutput("t4_dat_low", {31'b0, dat8}, 32'd0);
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h0);
    end
    checkOutput("t4_done_ready", {30'b0, done8, ready8}, 32'b11);
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h0);
    checkOutput("t4_b2b_start", {30'b0, busy8, dat8}, 32'b11);
    for (int i = 0; i < 9; i++) begin
      checkModel("t4_ff");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end

    // Clear after three bits of F0: idle next cycle, no done afterwards.
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      checkModel("t5_pre");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end
    checkModel("t5_pre");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    checkOutput("t5_abort", {27'b0, ready8, dat8, en8, busy8, done8}, 32'b10000);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t5_no_done", {31'b0, done8}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end

    // Asynchronous reset between edges mid-bit, then a fresh 81 transfer.
    applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 4'hA);
    for (int i = 0; i < 2; i++) begin
      checkModel("t6_pre");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end
    rst = 1'b1;
    #1;
    checkOutput("t6_async_b8", {27'b0, ready8, dat8, en8, busy8, done8}, 32'b10000);
    checkOutput("t6_async_b4", {27'b0, ready4, dat4, en4, busy4, done4}, 32'b10000);
    #1 rst = 1'b0;
    acc8 = -1;
    acc4 = -1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkModel("t6_idle");
    applyStimulus(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      checkModel("t6_run");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    end
    checkOutput("t6_done", {31'b0, done8}, 32'd1);
    checkOutput("t6_rx", {24'b0, rx}, 32'h81);

    // Random traffic on both instances against the reference model.
    for (int i = 0; i < 600; i++) begin
      checkModel("rand");
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                    $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 4'($urandom));
    end
    checkModel("rand_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sll_serializer.md
Name: sll_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end for sll_register, our serial-in/parallel-out shifter.
- Accepts a BITS-wide word through a valid/ready handshake.
- Shifts the word out MSB first, holding each bit for DIV clock cycles.
- Emits a per-bit strobe intended to drive the receiver's i_en, then pulses done.
- Sits between word-producing control logic and any serial link or loopback receiver in the design.

Parameters:
BITS, 32, word width; must be >= 2.
DIV, 1, clock cycles per serial bit; must be >= 1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
i_sclr  input  1  synchronous clear; aborts any transfer.
i_valid  input  1  producer presents a word on i_data.
i_data  input  BITS  parallel word to transmit.
o_ready  output  1  block can accept a word this cycle.
o_dat  output  1  serial data bit.
o_en  output  1  bit strobe; high in the last cycle of each bit period.
o_busy  output  1  transfer in progress.
o_done  output  1  one-cycle pulse after the final bit period.

Behaviour:
- Reset, asynchronous on rst high: state IDLE, shift reg 0, counters 0. Outputs: o_ready=1, o_dat=0, o_en=0, o_busy=0, o_done=0.
- Clear: i_sclr high at an edge has the same effect synchronously. rst has priority over i_sclr; i_sclr has priority over load and shift.
- States:
  - IDLE: o_ready=1, o_busy=0, o_dat=0.
  - SHIFT: o_ready=0, o_busy=1.
- Handshake:
  - A word is accepted at an edge where state=IDLE and i_valid=1.
  - i_data is captured into the shift reg; bit_cnt=0, div_cnt=0; state goes to SHIFT.
  - While o_ready=0, i_valid and i_data are ignored. No buffering.
- Data path: in SHIFT, o_dat = shift_reg[BITS-1] (registered, MSB first).
- Bit timing:
  - div_cnt counts 0..DIV-1 within each bit.
  - o_en is high when div_cnt==DIV-1, which is every SHIFT cycle when DIV=1.
  - On an o_en edge: shift reg shifts left with 0 fill, div_cnt wraps to 0, bit_cnt increments.
- Termination:
  - The o_en edge with bit_cnt==BITS-1 moves the state to IDLE.
  - In the following cycle o_done=1, o_ready=1, o_busy=0.
  - o_done lasts exactly one cycle.
- Latency: word accepted at edge k →
  - bits occupy cycles k+1 .. k+BITS*DIV;
  - o_done and o_ready high in cycle k+BITS*DIV+1;
  - exactly BITS o_en pulses per word.
- Back-to-back: a word presented with i_valid during the o_done cycle is accepted at that edge, with no idle gap beyond that one cycle.
- Abort: i_sclr or rst mid-transfer returns to IDLE with no o_done pulse and o_en low from the next cycle. A partially sent word is discarded.
- Widths:
  - bit_cnt: $clog2(BITS+1) bits.
  - div_cnt: max(1, $clog2(DIV)) bits.
  - Both are compared against constants only; they never wrap past their terminal value.
- Compatibility: o_dat/o_en wired to sll_register i_dat/i_en (same BITS) reproduces i_data on its o_data at the o_done cycle.

Decomposition:
- No shared package. State encoding (IDLE=0, SHIFT=1) is local parameters inside the module.
- One natural sub-module: bit_tick_gen, the DIV-cycle divider.
  - Inputs: clk, rst, clear, run.
  - Output: tick.
  - Reusable for other serial blocks in the design.

Test Plan:
1. BITS=8, DIV=1, load 8'hA5 at edge k → o_dat = 1,0,1,0,0,1,0,1 on cycles k+1..k+8; o_en high on all 8; o_done high only at k+9.
2. Loopback into sll_register (BITS=8), load 8'h3C → receiver o_data==8'h3C in the o_done cycle; exactly 8 o_en pulses counted.
3. DIV=3, BITS=4, load 4'b1001 → each bit held 3 cycles; o_en high on cycles k+3, k+6, k+9, k+12; o_done at k+13.
4. i_valid held high with new data (8'hFF) during a busy transfer of 8'h00 → o_dat stays 0 throughout; 8'hFF is accepted only at the o_done cycle, then sent immediately.
5. i_sclr pulsed after 3 bits of 8'hF0 → next cycle o_busy=0, o_ready=1, o_en=0, o_dat=0; no o_done pulse.
6. rst asserted asynchronously mid-bit (between edges) → outputs reach reset values before the next clk edge; after release, a fresh load of 8'h81 transmits correctly.
